// File: rtl/button_reader_pkg.sv
// Shared types and helpers for the front-panel button reader.
// Channel FSM encoding, board clock rate and a constant-safe clog2.
package button_reader_pkg;

   typedef enum logic [1:0] {
      ST_UP       = 2'd0,
      ST_UP_CHK   = 2'd1,
      ST_DOWN     = 2'd2,
      ST_DOWN_CHK = 2'd3
   } btn_st_e;

   localparam int unsigned CLK_HZ = 12000000;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, debounce FSM, optional long-press timer.
// Long-press logic is built only when BUTTON_READER_LONG_PRESS_EN is defined.
module button_channel
   import button_reader_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int LONG_CYCLES     = 12000000,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic CLK,
   input  logic RST,
   input  logic btn_in,
   output logic btn_state,
   output logic btn_press,
   output logic btn_release,
   output logic btn_long
);

   localparam int DB_W = clog2(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic REL = (ACTIVE_LOW != 0);

   if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_param
      $error("button_channel: cycle limits must be >= 2");
   end

   logic            sync1;
   logic            sync2;
   logic            pressed;
   btn_st_e         st;
   btn_st_e         st_nx;
   logic [DB_W-1:0] db_cnt;
   logic [DB_W-1:0] db_nx;
   logic            state_nx;
   logic            press_nx;
   logic            release_nx;

   assign pressed = sync2 ^ REL;

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1       <= REL;
         sync2       <= REL;
         st          <= ST_UP;
         db_cnt      <= '0;
         btn_state   <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
      end else begin
         sync1       <= btn_in;
         sync2       <= sync1;
         st          <= st_nx;
         db_cnt      <= db_nx;
         btn_state   <= state_nx;
         btn_press   <= press_nx;
         btn_release <= release_nx;
      end
   end

   always_comb begin
      st_nx      = st;
      db_nx      = db_cnt;
      state_nx   = btn_state;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      unique case (st)
         ST_UP: begin
            if (pressed) begin
               st_nx = ST_UP_CHK;
               db_nx = '0;
            end
         end
         ST_UP_CHK: begin
            if (!pressed) begin
               st_nx = ST_UP;
            end else if (db_cnt == DB_LAST) begin
               st_nx    = ST_DOWN;
               state_nx = 1'b1;
               press_nx = 1'b1;
            end else begin
               db_nx = db_cnt + 1'b1;
            end
         end
         ST_DOWN: begin
            if (!pressed) begin
               st_nx = ST_DOWN_CHK;
               db_nx = '0;
            end
         end
         ST_DOWN_CHK: begin
            if (pressed) begin
               st_nx = ST_DOWN;
            end else if (db_cnt == DB_LAST) begin
               st_nx      = ST_UP;
               state_nx   = 1'b0;
               release_nx = 1'b1;
            end else begin
               db_nx = db_cnt + 1'b1;
            end
         end
         default: st_nx = ST_UP;
      endcase
   end

`ifdef BUTTON_READER_LONG_PRESS_EN
   localparam int HOLD_W = clog2(LONG_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

   logic [HOLD_W-1:0] hold_cnt;
   logic              hold_done;
   logic              held;
   logic              long_nx;

   // Release bounces keep counting so a shaky hold still reaches the limit.
   always_comb begin
      held    = (st == ST_DOWN) || (st == ST_DOWN_CHK);
      long_nx = held && !hold_done && (hold_cnt == HOLD_LAST);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         hold_cnt  <= '0;
         hold_done <= 1'b0;
         btn_long  <= 1'b0;
      end else begin
         btn_long <= long_nx;
         if (press_nx) begin
            hold_cnt  <= '0;
            hold_done <= 1'b0;
         end else if (held) begin
            if (hold_cnt == HOLD_LAST) hold_done <= 1'b1;
            else hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end
`else
   assign btn_long = 1'b0;
`endif

endmodule

// File: rtl/button_reader.sv
// Multi-channel debounced button reader for the iCESugar front panel.
// Long-press pulses require BUTTON_READER_LONG_PRESS_EN; otherwise BTN_LONG is 0.
module button_reader
   import button_reader_pkg::*;
#(
   parameter int CHANNELS        = 4,
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int LONG_CYCLES     = 12000000,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [CHANNELS-1:0] BTN_IN,
   output logic [CHANNELS-1:0] BTN_STATE,
   output logic [CHANNELS-1:0] BTN_PRESS,
   output logic [CHANNELS-1:0] BTN_RELEASE,
   output logic [CHANNELS-1:0] BTN_LONG
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      button_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .LONG_CYCLES    (LONG_CYCLES),
         .ACTIVE_LOW     (ACTIVE_LOW)
      ) u_ch (
         .CLK        (CLK),
         .RST        (RST),
         .btn_in     (BTN_IN[i]),
         .btn_state  (BTN_STATE[i]),
         .btn_press  (BTN_PRESS[i]),
         .btn_release(BTN_RELEASE[i]),
         .btn_long   (BTN_LONG[i])
      );
   end

endmodule

// File: tb/tb_button_reader.sv
// Scoreboard bench for button_reader: run-length reference model, queued expectations.
// Long-press expectations follow whether BUTTON_READER_LONG_PRESS_EN is defined.
module tb_button_reader;

   localparam int CH = 2;
   localparam int D  = 4;
   localparam int L  = 20;
`ifdef BUTTON_READER_LONG_PRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [CH-1:0] BTN_IN = '1;
   logic [CH-1:0] BTN_STATE;
   logic [CH-1:0] BTN_PRESS;
   logic [CH-1:0] BTN_RELEASE;
   logic [CH-1:0] BTN_LONG;

   always #5 CLK = ~CLK;

   button_reader #(
      .CHANNELS       (CH),
      .DEBOUNCE_CYCLES(D),
      .LONG_CYCLES    (L),
      .ACTIVE_LOW     (1)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .BTN_IN     (BTN_IN),
      .BTN_STATE  (BTN_STATE),
      .BTN_PRESS  (BTN_PRESS),
      .BTN_RELEASE(BTN_RELEASE),
      .BTN_LONG   (BTN_LONG)
   );

   typedef struct packed {
      logic [CH-1:0] st;
      logic [CH-1:0] pr;
      logic [CH-1:0] rl;
      logic [CH-1:0] lg;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   // Reference model: raw pins delayed two samples, level flips after
   // D+1 consecutive disagreeing samples, long pulse L edges after press.
   logic [CH-1:0] raw_hist[$];
   int  run[CH];
   bit  lvl[CH];
   int  age[CH];
   int  m_press = 0, m_rel = 0, m_long = 0;
   int  o_press = 0, o_rel = 0, o_long = 0;

   task automatic model_reset();
      raw_hist = {};
      raw_hist.push_back('1);
      raw_hist.push_back('1);
      for (int c = 0; c < CH; c++) begin
         run[c] = 0;
         lvl[c] = 1'b0;
         age[c] = L;
      end
   endtask

   task automatic step(input logic rst, input logic [CH-1:0] pins);
      exp_t          e;
      logic [CH-1:0] p;
      @(negedge CLK);
      RST    = rst;
      BTN_IN = pins;
      e = '0;
      if (rst) begin
         model_reset();
      end else begin
         p = ~raw_hist.pop_front();
         raw_hist.push_back(pins);
         for (int c = 0; c < CH; c++) begin
            if (lvl[c] && LONG_EN && age[c] < L) begin
               age[c]++;
               if (age[c] == L) begin
                  e.lg[c] = 1'b1;
                  m_long++;
               end
            end
            if (p[c] != lvl[c]) begin
               run[c]++;
               if (run[c] == D + 1) begin
                  lvl[c] = p[c];
                  run[c] = 0;
                  if (p[c]) begin
                     e.pr[c] = 1'b1;
                     age[c]  = 0;
                     m_press++;
                  end else begin
                     e.rl[c] = 1'b1;
                     m_rel++;
                  end
               end
            end else begin
               run[c] = 0;
            end
            e.st[c] = lvl[c];
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic hold(input int n, input logic [CH-1:0] pins);
      for (int i = 0; i < n; i++) step(1'b0, pins);
   endtask

   exp_t me;
   always begin
      @(posedge CLK);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
         me = exp_q.pop_front();
         checks++;
         if (BTN_STATE !== me.st || BTN_PRESS !== me.pr ||
             BTN_RELEASE !== me.rl || BTN_LONG !== me.lg) begin
            errors++;
            $display("FAIL outputs cyc %0d: got st=%b pr=%b rl=%b lg=%b want st=%b pr=%b rl=%b lg=%b",
                     cyc, BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_LONG,
                     me.st, me.pr, me.rl, me.lg);
         end
         o_press += $countones(BTN_PRESS);
         o_rel   += $countones(BTN_RELEASE);
         o_long  += $countones(BTN_LONG);
      end
   end

   task automatic check_int(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   initial begin
      int first_press;
      int rem[CH];
      logic [CH-1:0] pins;
      model_reset();

      for (int i = 0; i < 3; i++) step(1'b1, 2'b11);

      first_press = 0;
      for (int i = 1; i <= 12; i++) begin
         step(1'b0, 2'b10);
         @(posedge CLK);
         #2;
         if (BTN_PRESS[0] && first_press == 0) first_press = i;
      end
      check_int("first_press_edge", first_press, 7);

      hold(10, 2'b11);
      hold(3, 2'b10);
      hold(10, 2'b11);
      hold(7, 2'b10);
      hold(10, 2'b11);
      hold(30, 2'b10);
      hold(12, 2'b11);
      hold(10, 2'b00);
      hold(10, 2'b10);
      hold(10, 2'b11);
      hold(4, 2'b10);
      step(1'b1, 2'b10);
      step(1'b1, 2'b10);
      hold(12, 2'b10);
      hold(12, 2'b11);

      pins = 2'b11;
      for (int c = 0; c < CH; c++) rem[c] = 1;
      for (int t = 0; t < 3000; t++) begin
         for (int c = 0; c < CH; c++) begin
            rem[c]--;
            if (rem[c] <= 0) begin
               pins[c] = ~pins[c];
               rem[c] = ($urandom_range(0, 5) == 0) ? $urandom_range(22, 32)
                                                    : $urandom_range(1, 9);
            end
         end
         step($urandom_range(0, 499) == 0, pins);
      end
      hold(30, 2'b11);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
      #2;
      check_int("drain_queue", exp_q.size(), 0);
      check_int("press_total", o_press, m_press);
      check_int("release_total", o_rel, m_rel);
      check_int("long_total", o_long, m_long);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
